day9_coord_parser: RTL

- Upstream front end of the day-9 tile-area stage.
- Consumes the puzzle input as an ASCII byte stream, one "x,y" line per red tile.
- Emits one parsed W-bit coordinate pair per line, qualified by a one-cycle valid pulse, for the corner-tracking/area stage.
- Also reports malformed-line statistics and end-of-input.

---
 rtl/day9_coord_parser_if.sv | 28 ++
 rtl/day9_coord_parser.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/day9_coord_parser_if.sv
// Byte-stream input and parsed-coordinate output bundle of the day-9 coordinate parser.
// The byte producer uses the master side; the parser uses the slave side.
interface day9_coord_parser_if #(
  parameter int W     = 17,
  parameter int CNT_W = 16,
  parameter int ERR_W = 8
);
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_last;
  logic             in_ready;
  logic [W-1:0]     x_coord;
  logic [W-1:0]     y_coord;
  logic             coord_valid;
  logic             done;
  logic [CNT_W-1:0] coord_count;
  logic [ERR_W-1:0] err_count;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, x_coord, y_coord, coord_valid, done, coord_count, err_count
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, x_coord, y_coord, coord_valid, done, coord_count, err_count
  );
endinterface

// File: rtl/day9_coord_parser.sv
// Parses an ASCII "x,y\n" stream into W-bit coordinate pairs, one pulse per line,
// counting malformed lines and flagging end of input.
module day9_coord_parser #(
  parameter int W     = 17,
  parameter int CNT_W = 16,
  parameter int ERR_W = 8
) (
  input logic               clock,
  input logic               reset,
  day9_coord_parser_if.slave bus
);
  localparam int AW = W + 4;
  localparam logic [AW-1:0] MAXV = {4'b0000, {W{1'b1}}};

  typedef enum logic [1:0] {S_X, S_Y, S_SKIP, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     x_acc_q, x_acc_d, y_acc_q, y_acc_d;
  logic             seen_x_q, seen_x_d, seen_y_q, seen_y_d;
  logic [W-1:0]     x_coord_q, y_coord_q, emit_x, emit_y;
  logic             coord_valid_q, done_q, ready_q;
  logic [CNT_W-1:0] coord_cnt_q;
  logic [ERR_W-1:0] err_cnt_q;
  logic             accept, emit, err, clr;
  logic             is_digit, is_comma, is_nl, is_ign;
  logic [AW-1:0]    dig, x_ext, y_ext, x_mul, y_mul;
  logic             x_ovf, y_ovf;

  function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [ERR_W-1:0] sat_err(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  assign accept   = bus.in_valid & ready_q;
  assign is_digit = (bus.in_data >= 8'h30) && (bus.in_data <= 8'h39);
  assign is_comma = (bus.in_data == 8'h2C);
  assign is_nl    = (bus.in_data == 8'h0A);
  assign is_ign   = (bus.in_data == 8'h0D) || (bus.in_data == 8'h20);

  // acc*10 + digit as shift-add, wide enough that the overflow test is exact
  assign dig   = AW'(bus.in_data[3:0]);
  assign x_ext = AW'(x_acc_q);
  assign y_ext = AW'(y_acc_q);
  assign x_mul = (x_ext << 3) + (x_ext << 1) + dig;
  assign y_mul = (y_ext << 3) + (y_ext << 1) + dig;
  assign x_ovf = (x_mul > MAXV);
  assign y_ovf = (y_mul > MAXV);

  always_comb begin
    state_d  = state_q;
    x_acc_d  = x_acc_q;
    y_acc_d  = y_acc_q;
    seen_x_d = seen_x_q;
    seen_y_d = seen_y_q;
    emit     = 1'b0;
    err      = 1'b0;
    clr      = 1'b0;
    emit_x   = x_acc_q;
    emit_y   = y_acc_q;
    if (accept) begin
      case (state_q)
        S_X: begin
          if (is_digit) begin
            if (x_ovf) err = 1'b1;
            else begin
              x_acc_d  = x_mul[W-1:0];
              seen_x_d = 1'b1;
            end
          end else if (is_comma) begin
            if (seen_x_q) state_d = S_Y;
            else          err = 1'b1;
          end else if (is_nl) begin
            if (seen_x_q) err = 1'b1;
          end else if (!is_ign) begin
            err = 1'b1;
          end
        end
        S_Y: begin
          if (is_digit) begin
            if (y_ovf) err = 1'b1;
            else begin
              y_acc_d  = y_mul[W-1:0];
              seen_y_d = 1'b1;
            end
          end else if (is_nl) begin
            if (seen_y_q) begin
              emit    = 1'b1;
              clr     = 1'b1;
              state_d = S_X;
            end else begin
              err = 1'b1;
            end
          end else if (!is_ign) begin
            err = 1'b1;
          end
        end
        S_SKIP: begin
          if (is_nl) begin
            state_d = S_X;
            clr     = 1'b1;
          end
        end
        default: ;
      endcase
      // A bad newline already ends the line, so there is nothing left to skip
      if (err) begin
        state_d = is_nl ? S_X : S_SKIP;
        clr     = 1'b1;
      end
      if (clr) begin
        x_acc_d  = '0;
        y_acc_d  = '0;
        seen_x_d = 1'b0;
        seen_y_d = 1'b0;
      end
      if (bus.in_last) begin
        if (state_d == S_Y && seen_y_d) begin
          emit   = 1'b1;
          emit_x = x_acc_d;
          emit_y = y_acc_d;
        end else if (!err && ((state_d == S_X && seen_x_d) || state_d == S_Y)) begin
          err = 1'b1;
        end
        state_d  = S_DONE;
        x_acc_d  = '0;
        y_acc_d  = '0;
        seen_x_d = 1'b0;
        seen_y_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= S_X;
      x_acc_q       <= '0;
      y_acc_q       <= '0;
      seen_x_q      <= 1'b0;
      seen_y_q      <= 1'b0;
      x_coord_q     <= '0;
      y_coord_q     <= '0;
      coord_valid_q <= 1'b0;
      done_q        <= 1'b0;
      ready_q       <= 1'b0;
      coord_cnt_q   <= '0;
      err_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      x_acc_q       <= x_acc_d;
      y_acc_q       <= y_acc_d;
      seen_x_q      <= seen_x_d;
      seen_y_q      <= seen_y_d;
      coord_valid_q <= emit;
      done_q        <= (state_d == S_DONE);
      ready_q       <= (state_d != S_DONE);
      if (emit) begin
        x_coord_q   <= emit_x;
        y_coord_q   <= emit_y;
        coord_cnt_q <= sat_cnt(coord_cnt_q);
      end
      if (err) err_cnt_q <= sat_err(err_cnt_q);
    end
  end

  assign bus.in_ready    = ready_q;
  assign bus.x_coord     = x_coord_q;
  assign bus.y_coord     = y_coord_q;
  assign bus.coord_valid = coord_valid_q;
  assign bus.done        = done_q;
  assign bus.coord_count = coord_cnt_q;
  assign bus.err_count   = err_cnt_q;
endmodule
